apb_to_reg_buf: RTL and testbench
=================================

# apb_to_reg_buf

Parametrised APB4-to-register-interface bridge. It latches the APB setup phase and drives a registered request on the register bus. It holds the APB access phase in wait states until the register slave responds, then returns a registered response. The block sits between the peripheral APB fabric and register-file slaves, and adds configurable widths, write strobes, privilege filtering and an optional access timeout.

## Interface
Parameters:
- AddrWidth, 32, width of paddr_i and reg_addr_o
- DataWidth, 32, data width; must be a multiple of 8 and at least 8 (elaboration error otherwise)
- PrivOnly, 1'b0, when 1, reject accesses with pprot_i[0]==0
- TimeoutCycles, 256, cycles in REQ before timeout; must be at least 2; used only with the timeout macro

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- pwrite_i  in  1  APB write
- paddr_i  in  AddrWidth  APB address
- pprot_i  in  3  APB protection
- pwdata_i  in  DataWidth  APB write data
- pstrb_i  in  DataWidth/8  APB write strobes
- prdata_o  out  DataWidth  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error
- reg_addr_o  out  AddrWidth  register address
- reg_write_o  out  1  register write
- reg_wdata_o  out  DataWidth  register write data
- reg_wstrb_o  out  DataWidth/8  register strobes
- reg_valid_o  out  1  register request valid
- reg_rdata_i  in  DataWidth  register read data
- reg_ready_i  in  1  register ready
- reg_error_i  in  1  register error
- timeout_o  out  1  one-cycle pulse when a transfer times out

## Operation
- The FSM has three states: IDLE, REQ and RESP. Reset state is IDLE.
- IDLE, on psel_i & !penable_i (setup phase):
  - latch paddr_i, pwrite_i and pwdata_i;
  - latch the strobes as pstrb_i for writes and '0 for reads.
  - If PrivOnly and pprot_i[0]==0: go to RESP with resp_err=1 and resp_data='0. No register request is issued.
  - Otherwise go to REQ.
- REQ:
  - reg_valid_o=1, driven from a flop. reg_addr_o, reg_write_o, reg_wdata_o and reg_wstrb_o are held stable.
  - On reg_ready_i=1: capture reg_rdata_i (forced to '0 for writes) and reg_error_i into the response registers, and go to RESP.
  - If psel_i drops while in REQ (master abort): drop valid, go to IDLE, and return no response.
- RESP:
  - pready_o=1; pslverr_o=resp_err; prdata_o=resp_data.
  - Go to IDLE in the next cycle unconditionally.
- Outside RESP, pready_o=0, pslverr_o=0 and prdata_o='0.
- A setup phase seen in REQ or RESP is ignored; APB forbids it.
- Request fields keep their last latched value in IDLE. reg_valid_o=0 in IDLE and RESP.

## Timing
- Reset values: reg_valid_o=0, pready_o=0, pslverr_o=0, timeout_o=0. prdata_o, reg_addr_o, reg_wdata_o and reg_wstrb_o are '0. reg_write_o=0.
- Cycle T0 is the setup phase. In T1, reg_valid_o=1.
  - If reg_ready_i=1 in T1, pready_o=1 in T2.
  - The minimum APB transfer is therefore 3 cycles (one wait state). Each extra cycle of reg_ready_i low adds one wait state.
- The privilege-reject path: setup in T0, pready_o=1 with pslverr_o=1 in T1.
- reg_valid_o stays asserted until a cycle with reg_ready_i=1; the slave sees exactly one handshake per transfer.
- Back-to-back: a new setup phase is accepted in the cycle after RESP (that cycle is IDLE).
- Asserting rst_ni low in any state returns the FSM to IDLE and zeros all outputs immediately (asynchronous). An in-flight request is dropped.

## Configuration
- APB_TO_REG_TIMEOUT_EN defined:
  - A counter of width $clog2(TimeoutCycles+1) is cleared on entry to REQ and increments each REQ cycle while reg_ready_i=0.
  - When it reaches TimeoutCycles-1 with reg_ready_i still 0: drop reg_valid_o, go to RESP with pslverr_o=1 and prdata_o='0, and pulse timeout_o for one cycle (the RESP cycle).
  - If reg_ready_i=1 in the same cycle the counter reaches TimeoutCycles-1, the ready wins and no timeout occurs.
- APB_TO_REG_TIMEOUT_EN undefined: the counter is absent, timeout_o is tied to 0, and REQ waits indefinitely.

## Test plan
- Write with paddr=0x40, pwdata=0xDEADBEEF, pstrb=4'b0011, reg_ready_i=1 immediately -> reg_valid_o in T1 with reg_wstrb_o=0011 and reg_wdata_o=0xDEADBEEF; pready_o=1, pslverr_o=0 in T2.
- Read at 0x44 with reg_ready_i delayed 3 cycles and reg_rdata_i=0x12345678 -> reg_wstrb_o=0; 3 extra wait states; prdata_o=0x12345678 for exactly one cycle.
- Read with reg_error_i=1 -> pslverr_o=1 with pready_o; PrivOnly=1 with pprot_i=3'b000 -> pslverr_o=1 in T1 and reg_valid_o never asserts.
- APB_TO_REG_TIMEOUT_EN with TimeoutCycles=4 and reg_ready_i held 0 -> reg_valid_o high for 4 cycles, then pslverr_o=1, prdata_o=0 and timeout_o=1 for one cycle. Repeat with ready in the last cycle -> no timeout.
- Back-to-back write then read with no idle gap -> both complete; the second setup is accepted in the cycle after the first pready_o.
- rst_ni asserted in REQ -> reg_valid_o drops at once; after release, a new transfer completes normally.

Source files
------------

// File: rtl/apb_to_reg_buf.sv
// apb_to_reg_buf: APB4 slave to register-bus master bridge.
//
// An APB setup phase is latched into a registered register-bus request.
// The APB access phase is held in wait states until the register slave
// handshakes. The response is then returned on a registered pready/pslverr/prdata.
// Accesses can be rejected on privilege (PrivOnly). An optional access timeout
// is enabled by defining APB_TO_REG_TIMEOUT_EN.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   psel_i .. pstrb_i    APB4 request (select, enable, write, addr, prot, data, strobes)
//   prdata_o, pready_o,  APB4 response (registered)
//   pslverr_o
//   reg_addr_o .. reg_valid_o  register-bus request (registered, stable while valid)
//   reg_rdata_i, reg_ready_i, reg_error_i  register-bus response
//   timeout_o            one-cycle pulse in the RESP cycle of a timed-out transfer
//
// Configuration macro: APB_TO_REG_TIMEOUT_EN (undefined: no timeout, timeout_o = 0)

module apb_to_reg_buf #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter logic        PrivOnly      = 1'b0,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [AddrWidth-1:0]   paddr_i,
    input  logic [2:0]             pprot_i,
    input  logic [DataWidth-1:0]   pwdata_i,
    input  logic [DataWidth/8-1:0] pstrb_i,
    output logic [DataWidth-1:0]   prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    output logic [AddrWidth-1:0]   reg_addr_o,
    output logic                   reg_write_o,
    output logic [DataWidth-1:0]   reg_wdata_o,
    output logic [DataWidth/8-1:0] reg_wstrb_o,
    output logic                   reg_valid_o,
    input  logic [DataWidth-1:0]   reg_rdata_i,
    input  logic                   reg_ready_i,
    input  logic                   reg_error_i,
    output logic                   timeout_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    // Elaboration-time parameter checks
    if ((DataWidth < 8) || ((DataWidth % 8) != 0)) begin : g_bad_data_width
        $error("apb_to_reg_buf: DataWidth must be a multiple of 8 and at least 8");
    end
    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("apb_to_reg_buf: TimeoutCycles must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                 r_state, w_state_d;

    logic [AddrWidth-1:0]   r_addr,    w_addr_d;
    logic                   r_write,   w_write_d;
    logic [DataWidth-1:0]   r_wdata,   w_wdata_d;
    logic [StrbWidth-1:0]   r_wstrb,   w_wstrb_d;
    logic                   r_valid,   w_valid_d;
    logic                   r_pready,  w_pready_d;
    logic                   r_pslverr, w_pslverr_d;
    logic [DataWidth-1:0]   r_prdata,  w_prdata_d;
    logic                   r_timeout, w_timeout_d;

    // Only the privileged bit of pprot is inspected
    logic w_unused_prot;
    assign w_unused_prot = ^pprot_i[2:1];

`ifdef APB_TO_REG_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0] r_cnt, w_cnt_d;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        w_state_d   = r_state;
        w_addr_d    = r_addr;
        w_write_d   = r_write;
        w_wdata_d   = r_wdata;
        w_wstrb_d   = r_wstrb;
        w_valid_d   = 1'b0;
        w_pready_d  = 1'b0;
        w_pslverr_d = 1'b0;
        w_prdata_d  = '0;
        w_timeout_d = 1'b0;
`ifdef APB_TO_REG_TIMEOUT_EN
        w_cnt_d     = r_cnt;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    w_addr_d  = paddr_i;
                    w_write_d = pwrite_i;
                    w_wdata_d = pwdata_i;
                    w_wstrb_d = pwrite_i ? pstrb_i : '0;
                    if (PrivOnly && !pprot_i[0]) begin
                        // Rejected without touching the register bus
                        w_state_d   = ST_RESP;
                        w_pready_d  = 1'b1;
                        w_pslverr_d = 1'b1;
                    end else begin
                        w_state_d = ST_REQ;
                        w_valid_d = 1'b1;
`ifdef APB_TO_REG_TIMEOUT_EN
                        w_cnt_d   = '0;
`endif
                    end
                end
            end
            ST_REQ: begin
                if (!psel_i) begin
                    // Master abort: drop the request, no response
                    w_state_d = ST_IDLE;
                end else if (reg_ready_i) begin
                    w_state_d   = ST_RESP;
                    w_pready_d  = 1'b1;
                    w_pslverr_d = reg_error_i;
                    w_prdata_d  = r_write ? '0 : reg_rdata_i;
`ifdef APB_TO_REG_TIMEOUT_EN
                end else if (r_cnt == CntWidth'(TimeoutCycles - 1)) begin
                    w_state_d   = ST_RESP;
                    w_pready_d  = 1'b1;
                    w_pslverr_d = 1'b1;
                    w_timeout_d = 1'b1;
                end else begin
                    w_valid_d = 1'b1;
                    w_cnt_d   = r_cnt + CntWidth'(1);
                end
`else
                end else begin
                    w_valid_d = 1'b1;
                end
`endif
            end
            ST_RESP: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Request fields and response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_valid   <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_addr    <= w_addr_d;
            r_write   <= w_write_d;
            r_wdata   <= w_wdata_d;
            r_wstrb   <= w_wstrb_d;
            r_valid   <= w_valid_d;
            r_pready  <= w_pready_d;
            r_pslverr <= w_pslverr_d;
            r_prdata  <= w_prdata_d;
            r_timeout <= w_timeout_d;
        end
    end

`ifdef APB_TO_REG_TIMEOUT_EN
    // Wait-cycle counter for the current REQ
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end
`endif

    assign prdata_o    = r_prdata;
    assign pready_o    = r_pready;
    assign pslverr_o   = r_pslverr;
    assign reg_addr_o  = r_addr;
    assign reg_write_o = r_write;
    assign reg_wdata_o = r_wdata;
    assign reg_wstrb_o = r_wstrb;
    assign reg_valid_o = r_valid;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_apb_to_reg_buf.sv
// Directed bench for apb_to_reg_buf: a PrivOnly=0 instance (dut) and a
// PrivOnly=1 instance (dut_p) with separate psel; TimeoutCycles=4 on both.
module tb_apb_to_reg_buf;

    logic        clk;
    logic        rst_n;
    logic        psel, psel_p, penable, pwrite;
    logic [31:0] paddr, pwdata, reg_rdata;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
    logic        reg_ready, reg_error;

    logic [31:0] prdata, reg_addr, reg_wdata;
    logic        pready, pslverr, reg_write, reg_valid, tmo;
    logic [3:0]  reg_wstrb;

    logic [31:0] prdata_p, reg_addr_p, reg_wdata_p;
    logic        pready_p, pslverr_p, reg_write_p, reg_valid_p, tmo_p;
    logic [3:0]  reg_wstrb_p;

    int n_vec = 0;
    int n_err = 0;

    apb_to_reg_buf #(.AddrWidth(32), .DataWidth(32), .PrivOnly(1'b0), .TimeoutCycles(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pprot_i(pprot), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
        .reg_addr_o(reg_addr), .reg_write_o(reg_write), .reg_wdata_o(reg_wdata),
        .reg_wstrb_o(reg_wstrb), .reg_valid_o(reg_valid), .reg_rdata_i(reg_rdata),
        .reg_ready_i(reg_ready), .reg_error_i(reg_error), .timeout_o(tmo)
    );

    apb_to_reg_buf #(.AddrWidth(32), .DataWidth(32), .PrivOnly(1'b1), .TimeoutCycles(4)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .psel_i(psel_p), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pprot_i(pprot), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata_p), .pready_o(pready_p), .pslverr_o(pslverr_p),
        .reg_addr_o(reg_addr_p), .reg_write_o(reg_write_p), .reg_wdata_o(reg_wdata_p),
        .reg_wstrb_o(reg_wstrb_p), .reg_valid_o(reg_valid_p), .reg_rdata_i(reg_rdata),
        .reg_ready_i(reg_ready), .reg_error_i(reg_error), .timeout_o(tmo_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs set and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        psel = 0; psel_p = 0; penable = 0; reg_ready = 0; reg_error = 0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++; if ({reg_valid, pready, pslverr, tmo, reg_write} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b want 00000", {reg_valid, pready, pslverr, tmo, reg_write}); n_err++; end
        n_vec++; if ({prdata, reg_addr, reg_wdata, reg_wstrb} !== 100'b0) begin
            $display("FAIL reset_data: got %h want 0", {prdata, reg_addr, reg_wdata, reg_wstrb}); n_err++; end
        n_vec++; if ({reg_valid_p, pready_p, pslverr_p, tmo_p} !== 4'b0) begin
            $display("FAIL reset_ctrl_p: got %b want 0000", {reg_valid_p, pready_p, pslverr_p, tmo_p}); n_err++; end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_write();
        paddr = 32'h40; pwrite = 1; pwdata = 32'hDEADBEEF; pstrb = 4'b0011; pprot = 3'b001;
        reg_rdata = 32'hFFFF_FFFF; reg_ready = 1; psel = 1; penable = 0;
        tick(); // T1
        n_vec++; if (reg_valid !== 1'b1) begin $display("FAIL wr_valid_t1: got %b want 1", reg_valid); n_err++; end
        n_vec++; if (reg_wstrb !== 4'b0011) begin $display("FAIL wr_wstrb: got %b want 0011", reg_wstrb); n_err++; end
        n_vec++; if (reg_wdata !== 32'hDEADBEEF) begin $display("FAIL wr_wdata: got %h want deadbeef", reg_wdata); n_err++; end
        n_vec++; if ({reg_addr, reg_write} !== {32'h40, 1'b1}) begin
            $display("FAIL wr_addr_write: got %h/%b want 40/1", reg_addr, reg_write); n_err++; end
        n_vec++; if (pready !== 1'b0) begin $display("FAIL wr_pready_t1: got %b want 0", pready); n_err++; end
        penable = 1;
        tick(); // T2
        n_vec++; if ({pready, pslverr, reg_valid} !== 3'b100) begin
            $display("FAIL wr_resp_t2: got %b want 100", {pready, pslverr, reg_valid}); n_err++; end
        n_vec++; if (prdata !== 32'h0) begin $display("FAIL wr_prdata_zero: got %h want 0", prdata); n_err++; end
        bus_idle();
        tick(); // T3
        n_vec++; if (pready !== 1'b0) begin $display("FAIL wr_pready_t3: got %b want 0", pready); n_err++; end
    endtask

    task automatic test_read_wait();
        paddr = 32'h44; pwrite = 0; pstrb = 4'hF; reg_rdata = 32'h12345678; reg_ready = 0;
        psel = 1; penable = 0;
        tick(); // T1
        n_vec++; if (reg_wstrb !== 4'b0000) begin $display("FAIL rd_wstrb: got %b want 0000", reg_wstrb); n_err++; end
        penable = 1;
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if ({reg_valid, pready} !== 2'b10) begin
                $display("FAIL rd_wait_T%0d: got valid/pready %b want 10", i, {reg_valid, pready}); n_err++; end
            if (i == 4) reg_ready = 1;
            tick();
        end
        // T5
        n_vec++; if ({pready, pslverr, reg_valid} !== 3'b100) begin
            $display("FAIL rd_resp_t5: got %b want 100", {pready, pslverr, reg_valid}); n_err++; end
        n_vec++; if (prdata !== 32'h12345678) begin $display("FAIL rd_prdata: got %h want 12345678", prdata); n_err++; end
        bus_idle();
        tick(); // T6
        n_vec++; if ({pready, prdata} !== 33'h0) begin
            $display("FAIL rd_prdata_one_cycle: got %b/%h want 0/0", pready, prdata); n_err++; end
    endtask

    task automatic test_read_err();
        paddr = 32'h4C; pwrite = 0; reg_rdata = 32'hA5A5A5A5; reg_ready = 1; reg_error = 1;
        psel = 1; penable = 0;
        tick(); penable = 1;
        tick(); // T2
        n_vec++; if ({pready, pslverr} !== 2'b11) begin $display("FAIL err_resp: got %b want 11", {pready, pslverr}); n_err++; end
        n_vec++; if (prdata !== 32'hA5A5A5A5) begin $display("FAIL err_prdata: got %h want a5a5a5a5", prdata); n_err++; end
        bus_idle();
        tick();
        n_vec++; if (pslverr !== 1'b0) begin $display("FAIL err_clear: got %b want 0", pslverr); n_err++; end
    endtask

    task automatic test_priv();
        paddr = 32'h80; pwrite = 0; pprot = 3'b000; reg_rdata = 32'h55AA55AA; reg_ready = 1;
        psel_p = 1; penable = 0;
        tick(); // T1
        n_vec++; if ({pready_p, pslverr_p, reg_valid_p} !== 3'b110) begin
            $display("FAIL priv_reject_t1: got %b want 110", {pready_p, pslverr_p, reg_valid_p}); n_err++; end
        n_vec++; if (prdata_p !== 32'h0) begin $display("FAIL priv_prdata: got %h want 0", prdata_p); n_err++; end
        penable = 1;
        tick(); // T2
        n_vec++; if ({pready_p, reg_valid_p} !== 2'b00) begin
            $display("FAIL priv_t2: got %b want 00", {pready_p, reg_valid_p}); n_err++; end
        bus_idle();
        tick();
        // Privileged access passes on the same instance
        pprot = 3'b001; reg_rdata = 32'h11223344; reg_ready = 1; psel_p = 1; penable = 0;
        tick();
        n_vec++; if (reg_valid_p !== 1'b1) begin $display("FAIL priv_ok_valid: got %b want 1", reg_valid_p); n_err++; end
        penable = 1;
        tick();
        n_vec++; if ({pready_p, pslverr_p, prdata_p} !== {2'b10, 32'h11223344}) begin
            $display("FAIL priv_ok_resp: got %b/%b/%h want 1/0/11223344", pready_p, pslverr_p, prdata_p); n_err++; end
        bus_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        paddr = 32'h50; pwrite = 1; pwdata = 32'h01020304; pstrb = 4'hF; reg_ready = 1;
        psel = 1; penable = 0;
        tick(); penable = 1;
        tick(); // T2
        n_vec++; if (pready !== 1'b1) begin $display("FAIL b2b_first_pready: got %b want 1", pready); n_err++; end
        tick(); // T3: second setup driven with no idle gap
        paddr = 32'h54; pwrite = 0; reg_rdata = 32'h0BADC0DE; penable = 0;
        n_vec++; if ({pready, reg_valid} !== 2'b00) begin
            $display("FAIL b2b_idle_cycle: got %b want 00", {pready, reg_valid}); n_err++; end
        tick(); // T4
        n_vec++; if ({reg_valid, reg_write, reg_addr} !== {2'b10, 32'h54}) begin
            $display("FAIL b2b_second_req: got %b/%b/%h want 1/0/54", reg_valid, reg_write, reg_addr); n_err++; end
        penable = 1;
        tick(); // T5
        n_vec++; if ({pready, prdata} !== {1'b1, 32'h0BADC0DE}) begin
            $display("FAIL b2b_second_resp: got %b/%h want 1/0badc0de", pready, prdata); n_err++; end
        bus_idle();
        tick();
    endtask

    task automatic test_abort();
        paddr = 32'h58; pwrite = 0; reg_ready = 0; psel = 1; penable = 0;
        tick(); penable = 1;
        n_vec++; if (reg_valid !== 1'b1) begin $display("FAIL abort_valid: got %b want 1", reg_valid); n_err++; end
        psel = 0; penable = 0;
        tick();
        n_vec++; if ({reg_valid, pready} !== 2'b00) begin
            $display("FAIL abort_drop: got %b want 00", {reg_valid, pready}); n_err++; end
        tick();
        n_vec++; if (pready !== 1'b0) begin $display("FAIL abort_no_resp: got %b want 0", pready); n_err++; end
    endtask

    task automatic test_timeout();
`ifdef APB_TO_REG_TIMEOUT_EN
        paddr = 32'h60; pwrite = 0; reg_rdata = 32'hFEEDFACE; reg_ready = 0; psel = 1; penable = 0;
        tick(); penable = 1;
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if ({reg_valid, tmo} !== 2'b10) begin
                $display("FAIL tmo_wait_T%0d: got %b want 10", i, {reg_valid, tmo}); n_err++; end
            tick();
        end
        n_vec++; if ({reg_valid, pready, pslverr, tmo, prdata} !== {4'b0111, 32'h0}) begin
            $display("FAIL tmo_resp: got %b/%h want 0111/0", {reg_valid, pready, pslverr, tmo}, prdata); n_err++; end
        bus_idle();
        tick();
        n_vec++; if ({tmo, pready} !== 2'b00) begin $display("FAIL tmo_pulse: got %b want 00", {tmo, pready}); n_err++; end
        // Ready in the last allowed cycle wins
        psel = 1; penable = 0;
        tick(); penable = 1;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) reg_ready = 1;
            tick();
        end
        n_vec++; if ({pready, pslverr, tmo, prdata} !== {3'b100, 32'hFEEDFACE}) begin
            $display("FAIL tmo_ready_wins: got %b/%h want 100/feedface", {pready, pslverr, tmo}, prdata); n_err++; end
        bus_idle();
        tick();
`else
        paddr = 32'h60; pwrite = 0; reg_rdata = 32'hFEEDFACE; reg_ready = 0; psel = 1; penable = 0;
        tick(); penable = 1;
        for (int i = 0; i < 12; i++) tick();
        n_vec++; if ({reg_valid, pready, tmo} !== 3'b100) begin
            $display("FAIL no_tmo_wait: got %b want 100", {reg_valid, pready, tmo}); n_err++; end
        reg_ready = 1;
        tick();
        n_vec++; if ({pready, tmo, prdata} !== {2'b10, 32'hFEEDFACE}) begin
            $display("FAIL no_tmo_resp: got %b/%h want 10/feedface", {pready, tmo}, prdata); n_err++; end
        bus_idle();
        tick();
`endif
    endtask

    task automatic test_reset_in_req();
        paddr = 32'h70; pwrite = 1; pwdata = 32'h99; pstrb = 4'h1; reg_ready = 0; psel = 1; penable = 0;
        tick(); penable = 1;
        n_vec++; if (reg_valid !== 1'b1) begin $display("FAIL rst_req_valid: got %b want 1", reg_valid); n_err++; end
        rst_n = 0;
        #1;
        n_vec++; if ({reg_valid, reg_addr, reg_wdata} !== 65'h0) begin
            $display("FAIL rst_async_drop: got %b/%h/%h want 0/0/0", reg_valid, reg_addr, reg_wdata); n_err++; end
        bus_idle();
        tick();
        rst_n = 1;
        tick();
        paddr = 32'h48; pwrite = 0; reg_rdata = 32'hCAFEF00D; reg_ready = 1; psel = 1; penable = 0;
        tick(); penable = 1;
        n_vec++; if ({reg_valid, reg_addr} !== {1'b1, 32'h48}) begin
            $display("FAIL rst_after_req: got %b/%h want 1/48", reg_valid, reg_addr); n_err++; end
        tick();
        n_vec++; if ({pready, prdata} !== {1'b1, 32'hCAFEF00D}) begin
            $display("FAIL rst_after_resp: got %b/%h want 1/cafef00d", pready, prdata); n_err++; end
        bus_idle();
        tick();
    endtask

    initial begin
        rst_n = 0; paddr = 0; pwrite = 0; pwdata = 0; pstrb = 0; pprot = 3'b001; reg_rdata = 0;
        bus_idle();
        test_reset();
        test_write();
        test_read_wait();
        test_read_err();
        test_priv();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_reset_in_req();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
